mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers; the consumer of the 3-bit `toMult` code produced by ALU control. Executes MULT, MULTU, DIV, DIVU in a fixed WIDTH+1-cycle busy window, executes MTHI/MTLO in one cycle, and returns HI/LO for MFHI/MFLO. Sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

## Interface

Parameters:
- WIDTH, 32, operand/HI/LO width; latencies below scale with WIDTH

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; accepted only when busy=0
- op  input  3  011 MULT, 001 MULTU, 010 DIV, 000 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  iterative operation in progress
- done  output  1  one-cycle pulse: new HI/LO visible this cycle
- result  output  WIDTH  combinational: hi when op=110, else lo
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation

- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1: op 011/001 -> latch a, b (as magnitudes plus sign flags for 011), counter=0, go MUL; op 010/000 -> same, go DIV; op 100 -> hi<=a at that edge, stay IDLE; op 101 -> lo<=a; op 110/111 -> no state change.
- MUL: one shift-add step per cycle, 2·WIDTH-bit accumulator, WIDTH steps, then FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit), WIDTH steps, then FIX.
- FIX: apply signs, write hi/lo, return to IDLE, assert done the following cycle.
- Arithmetic:
  - MULT: two's-complement 2·WIDTH-bit product, {hi,lo}.
  - MULTU: unsigned product.
  - DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
  - MULT negates the 2·WIDTH product when signs differ. DIV negates the quotient when signs differ and negates the remainder when the dividend is negative.
- Boundaries:
  - Divide by zero (DIV or DIVU): lo=all ones, hi=a as latched, regardless of sign.
  - DIV of most-negative by -1: lo=most-negative, hi=0.
  - start while busy=1: ignored entirely, including MTHI/MTLO; no queuing.
  - Operands are sampled only at acceptance; later changes on a/b have no effect.
- Reset (any state, including mid-operation): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0; an in-flight result is discarded.

## Timing

- Acceptance edge E: start=1 and busy=0 sampled at E.
- MULT/MULTU/DIV/DIVU:
  - busy=1 from the cycle after E for WIDTH+1 cycles (WIDTH iterations + FIX).
  - hi/lo update at the edge ending FIX.
  - done=1 for exactly one cycle, the first cycle with busy=0 again.
  - Start-to-done latency is WIDTH+2 edges (34 at WIDTH=32).
- A new start is accepted in the done cycle (back-to-back allowed). hi/lo then hold the previous result until the next FIX.
- MTHI/MTLO: hi/lo change at E. busy and done stay 0. Visible on result the next cycle.
- MFHI/MFLO: result is valid combinationally in any cycle with busy=0. During busy, result shows the old hi/lo.
- hi/lo never change except at MTHI/MTLO acceptance, FIX, or reset.

## Test plan

- MULTU a=FFFFFFFF, b=FFFFFFFF:
  - busy high 33 cycles.
  - done on edge E+34 with hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. Then MFLO -> result=FFFFFFEB.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=00000007, b=0 -> lo=FFFFFFFF, hi=00000007. Then DIVU a=64, b=7 -> lo=0E, hi=02.
- MTHI a=12345678, then MFHI next cycle -> result=12345678 with busy=0. Then start MULTU 3×5 and pulse MTLO a=AAAA during busy -> MTLO ignored; final lo=0000000F, hi=0.
- Start MULT 2×3, assert reset on cycle 10 of busy -> next cycle busy=0, hi=lo=0, no done pulse. A fresh MULTU 2×3 then yields lo=6 after 34 edges.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit                                                              |
// | Iterative shift-add multiplier / restoring divider with HI/LO registers.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_neg_res, r_neg_rem, r_is_div, r_dz, r_done;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign busy   = (r_state != c_st_idle);
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign result = (op == 3'b110) ? r_hi : r_lo;

    // op[1] marks the signed variants (MULT/DIV); magnitudes are iterated on
    assign w_signed = op[1];
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditionally add multiplicand to upper half, shift right
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

    // Divide step: upper half is the partial remainder, lower half shifts in quotient bits
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start && !op[2]) w_state_nxt = op[0] ? c_st_mul : c_st_div;
            c_st_mul,
            c_st_div:  if (r_cnt == c_last) w_state_nxt = c_st_fix;
            c_st_fix:  w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_a_raw   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_is_div  <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_cnt     <= '0;
                            r_a_raw   <= a;
                            r_is_div  <= ~op[0];
                            r_dz      <= ~op[0] && (b == '0);
                            r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_rem <= w_signed && a[WIDTH-1];
                            r_opnd    <= op[0] ? w_a_mag : w_b_mag;
                            r_acc     <= {{WIDTH{1'b0}}, (op[0] ? w_b_mag : w_a_mag)};
                        end else if (op == 3'b100) begin
                            r_hi <= a;
                        end else if (op == 3'b101) begin
                            r_lo <= a;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                end
                c_st_div: begin
                    r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_dz) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
